ped_button_pulse: RTL and testbench
===================================

// Module: ped_button_pulse
// PURPOSE
//   Pedestrian push-button front end. Produces the one-cycle btnpress strobe consumed by
//   the pedestrian press counter. Synchronises the raw asynchronous button, debounces
//   both press and release, and emits exactly one pulse per confirmed press.
//   Sits between the board button pin and the press counter.
// PARAMETERS
//   DB_CYCLES  500000  stable cycles required to accept a level change (10 ms @ 50 MHz); >= 2
//   CNT_W      20      debounce counter width; must hold DB_CYCLES-1
// PORTS
//   clk        in   1  system clock, all logic on posedge
//   rst        in   1  asynchronous, active-low reset (0 = reset)
//   btn_raw    in   1  raw button pin, asynchronous, bouncy, 1 = pressed
//   btnpress   out  1  registered one-cycle strobe per accepted press
//   btn_level  out  1  registered debounced button level
// BEHAVIOUR
//   Reset (rst=0, async): sync flops=0, cnt=0, state=IDLE, btnpress=0, btn_level=0.
//   Sync: two-flop chain btn_raw -> s1 -> btn_s. FSM uses only btn_s.
//   FSM (cnt cleared on every state change):
//     IDLE:         btn_s=1 -> PRESS_WAIT.
//     PRESS_WAIT:   btn_s=0 -> IDLE, no pulse (bounce).
//                   btn_s=1 & cnt<DB_CYCLES-1 -> cnt+1.
//                   btn_s=1 & cnt==DB_CYCLES-1 -> HELD; btnpress=1 next cycle.
//     HELD:         btn_level=1; btn_s=0 -> RELEASE_WAIT.
//     RELEASE_WAIT: btn_level stays 1.
//                   btn_s=1 -> HELD, no new pulse.
//                   btn_s=0 & cnt==DB_CYCLES-1 -> IDLE; btn_level=0 next cycle.
//                   otherwise cnt+1.
//   Latency: raw first sampled high at edge k (stable) -> btnpress high for the one
//     cycle after edge k+DB_CYCLES+2. Release latency is identical, seen on btn_level.
//   btnpress:
//     - high for exactly one clk per IDLE->...->HELD traversal.
//     - no auto-repeat however long the button is held.
//     - never asserted in the same cycle as reset.
//   cnt never exceeds DB_CYCLES-1 and never wraps. Unused state encodings -> IDLE.
//   Reset mid-operation: in-flight debounce is discarded and no pulse is emitted.
//     If the button is still held at reset release, a fresh full debounce runs,
//     then one pulse is emitted.
//   Bounce shorter than DB_CYCLES stable cycles never reaches btnpress or btn_level.
// TESTING  (DB_CYCLES=4 for simulation)
//   1. rst=0 then 1; raw=1 from edge k, held 20 cycles, then 0 -> btnpress=1 only in
//      cycle after edge k+6; btn_level 1 from then until 6 cycles after release is sampled.
//   2. raw toggles 1,1,0,1,1,1,0 (runs < 4) -> btnpress never 1, btn_level stays 0.
//   3. In HELD, raw=0 for 2 cycles then 1 -> btn_level stays 1, no second pulse.
//   4. rst=0 while in PRESS_WAIT with raw=1 held -> outputs 0 at once.
//      After rst=1: exactly one pulse, 6 cycles after first sample.
//   5. raw held 1000 cycles -> exactly one btnpress pulse.
//   6. 10 clean presses (8 high / 10 low), btnpress driving the 32-bit press counter
//      -> exactly 10 pulses; counter reads 32'd10.

Source files
------------

// File: rtl/ped_button_pulse_if.sv
// Button-side signal bundle: raw pin in, debounced level and press strobe out.
interface ped_button_pulse_if;
  logic btn_raw;
  logic btnpress;
  logic btn_level;

  modport master (output btn_raw, input btnpress, input btn_level);
  modport slave  (input btn_raw, output btnpress, output btn_level);
endinterface

// File: rtl/ped_button_pulse.sv
// Pedestrian button front end: two-flop synchroniser, press/release debounce FSM,
// and a single one-cycle btnpress strobe per confirmed press.
module ped_button_pulse #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 20
) (
  input  logic              clk,
  input  logic              rst,
  ped_button_pulse_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             s1_reg;
  logic             btn_s_reg;
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             btnpress_reg;
  logic             btn_level_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_reg    <= 1'b0;
      btn_s_reg <= 1'b0;
    end else begin
      s1_reg    <= bus.btn_raw;
      btn_s_reg <= s1_reg;
    end
  end

  // cnt is cleared on every state change so each wait starts a fresh stability window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      btnpress_reg  <= 1'b0;
      btn_level_reg <= 1'b0;
    end else begin
      btnpress_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          btn_level_reg <= 1'b0;
          if (btn_s_reg) begin
            state_reg <= PRESS_WAIT;
            cnt_reg   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s_reg) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            state_reg     <= HELD;
            cnt_reg       <= '0;
            btnpress_reg  <= 1'b1;
            btn_level_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HELD: begin
          btn_level_reg <= 1'b1;
          if (!btn_s_reg) begin
            state_reg <= RELEASE_WAIT;
            cnt_reg   <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to pressed returns to HELD without a second strobe.
          if (btn_s_reg) begin
            state_reg <= HELD;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            btn_level_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          cnt_reg       <= '0;
          btn_level_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.btnpress  = btnpress_reg;
  assign bus.btn_level = btn_level_reg;

endmodule

// File: tb/tb_ped_button_pulse.sv
// Randomised and directed bench for ped_button_pulse against a run-length reference model.
module tb_ped_button_pulse;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ped_button_pulse_if bus ();

  ped_button_pulse #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int pulses = 0;
  int pulse_cyc = -1;
  logic [31:0] press_count = '0;

  // Reference: debounced level flips once the synchronised input has disagreed
  // with it on DB+1 consecutive edges; a flip to 1 is a press.
  bit m_s1, m_s2, m_level, m_press;
  int run;
  int m_pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; run = 0;
  endtask

  task automatic step(input logic r);
    bus.btn_raw = r;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      model_reset();
    end else begin
      m_press = 0;
      if (m_s2 != m_level) begin
        run++;
        if (run == DB + 1) begin
          m_level = m_s2;
          run = 0;
          if (m_level) begin
            m_press = 1;
            m_pulses++;
          end
        end
      end else begin
        run = 0;
      end
      m_s2 = m_s1;
      m_s1 = r;
    end
    #1;
    check("btnpress", bus.btnpress, m_press);
    check("btn_level", bus.btn_level, m_level);
    if (bus.btnpress === 1'b1) begin
      pulses++;
      pulse_cyc = cyc;
      press_count++;
      $display("press %0d seen at cycle %0d", pulses, cyc);
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, k, r, last_lvl, mp0;
    bit seen, val;
    bit [6:0] bounce;
    bus.btn_raw = 1'b0;
    model_reset();
    #1;
    check("rst_btnpress", bus.btnpress, 0);
    check("rst_btn_level", bus.btn_level, 0);
    @(negedge clk);
    step(0); step(0);
    rst = 1'b1;
    step(0); step(0);

    // 1: clean press, latency of strobe and of release on btn_level
    p0 = pulses; k = cyc + 1;
    repeat (20) step(1);
    check("t1_pulse_cycle", pulse_cyc, k + 6);
    check("t1_pulse_count", pulses - p0, 1);
    r = cyc + 1; last_lvl = -1;
    repeat (10) begin
      step(0);
      if (bus.btn_level === 1'b1) last_lvl = cyc;
    end
    check("t1_release_cycle", last_lvl, r + 5);

    // 2: short runs never get through
    p0 = pulses; seen = 0;
    bounce = 7'b0111011;
    for (int i = 6; i >= 0; i--) begin
      step(bounce[i]);
      if (bus.btn_level !== 1'b0) seen = 1;
    end
    repeat (10) begin
      step(0);
      if (bus.btn_level !== 1'b0) seen = 1;
    end
    check("t2_pulse_count", pulses - p0, 0);
    check("t2_level_seen", seen, 0);

    // 3: release bounce while held
    p0 = pulses;
    repeat (10) step(1);
    seen = 0;
    step(0); if (bus.btn_level !== 1'b1) seen = 1;
    step(0); if (bus.btn_level !== 1'b1) seen = 1;
    repeat (10) begin
      step(1);
      if (bus.btn_level !== 1'b1) seen = 1;
    end
    check("t3_pulse_count", pulses - p0, 1);
    check("t3_level_drop", seen, 0);
    repeat (12) step(0);

    // 4: reset during PRESS_WAIT, fresh debounce afterwards
    p0 = pulses;
    repeat (3) step(1);
    rst = 1'b0;
    #1;
    check("t4_rst_btnpress", bus.btnpress, 0);
    check("t4_rst_btn_level", bus.btn_level, 0);
    model_reset();
    @(negedge clk);
    step(1); step(1);
    rst = 1'b1;
    k = cyc + 1;
    repeat (14) step(1);
    check("t4_pulse_count", pulses - p0, 1);
    check("t4_pulse_cycle", pulse_cyc, k + 6);
    repeat (12) step(0);

    // 5: long hold, no auto-repeat
    p0 = pulses;
    repeat (1000) step(1);
    check("t5_pulse_count", pulses - p0, 1);
    repeat (12) step(0);

    // 6: ten clean presses into the press counter
    press_count = '0;
    repeat (10) begin
      repeat (8) step(1);
      repeat (10) step(0);
    end
    check("t6_press_counter", press_count, 32'd10);

    // random bursts of bounce and real presses
    p0 = pulses; mp0 = m_pulses; val = 0;
    repeat (300) begin
      val = ~val;
      repeat ($urandom_range(1, 9)) step(val);
    end
    repeat (12) step(0);
    check("rand_pulse_count", pulses - p0, m_pulses - mp0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
